// File: rtl/fx_slave_regs.sv
// fx bus responder: byte register bank, shadowed 32-bit config word with
// atomic commit on byte 3, and an event FIFO drained through a pop address.
module fx_slave_regs #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
  parameter int          NUM_REG    = 16,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic                 fx_wr,
  input  logic [31:0]          fx_waddr,
  input  logic [7:0]           fx_data,
  input  logic                 fx_rd,
  input  logic [31:0]          fx_raddr,
  output logic [7:0]           fx_q,
  output logic [NUM_REG*8-1:0] reg_out,
  output logic [31:0]          cfg_word,
  output logic                 cfg_upd,
  input  logic [7:0]           ev_data,
  input  logic                 ev_vld,
  output logic                 ev_full
);

  localparam int RIW = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [31:0] OFF_SH   = 32'(NUM_REG);
  localparam logic [31:0] OFF_POP  = 32'(NUM_REG + 4);
  localparam logic [31:0] OFF_STAT = 32'(NUM_REG + 5);

  // ---------------------------------------------------------------- decode
  logic [31:0] woff, roff;
  logic        w_in, r_in;
  logic        w_reg, w_sh, r_reg, r_sh, r_pop, r_stat;
  logic [1:0]  sh_widx, sh_ridx;
  logic [RIW-1:0] widx, ridx;

  assign woff = fx_waddr - BASE_ADDR;
  assign roff = fx_raddr - BASE_ADDR;
  // Addresses below the window must not alias through the wrapped subtraction.
  assign w_in = (fx_waddr >= BASE_ADDR);
  assign r_in = (fx_raddr >= BASE_ADDR);

  assign w_reg  = fx_wr && w_in && (woff < OFF_SH);
  assign w_sh   = fx_wr && w_in && (woff >= OFF_SH) && (woff < OFF_POP);
  assign r_reg  = r_in && (roff < OFF_SH);
  assign r_sh   = r_in && (roff >= OFF_SH) && (roff < OFF_POP);
  assign r_pop  = r_in && (roff == OFF_POP);
  assign r_stat = r_in && (roff == OFF_STAT);

  assign sh_widx = 2'(woff - OFF_SH);
  assign sh_ridx = 2'(roff - OFF_SH);
  assign widx    = woff[RIW-1:0];
  assign ridx    = roff[RIW-1:0];

  // ---------------------------------------------------------- register bank
  logic [7:0] reg_bank [NUM_REG];

  generate
    for (genvar gi = 0; gi < NUM_REG; gi++) begin : g_reg
      // One byte register per offset, written when the decoded index matches.
      always_ff @(posedge clk_sys or posedge rst) begin
        if (rst)
          reg_bank[gi] <= '0;
        else if (w_reg && (widx == RIW'(gi)))
          reg_bank[gi] <= fx_data;
      end
      assign reg_out[8*gi +: 8] = reg_bank[gi];
    end
  endgenerate

  // ----------------------------------------------------- shadow and config
  logic [31:0] shadow_reg;

  // Shadow bytes collect the next config; writing byte 3 commits all four.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      shadow_reg <= '0;
      cfg_word   <= '0;
      cfg_upd    <= 1'b0;
    end else begin
      cfg_upd <= 1'b0;
      if (w_sh) begin
        shadow_reg[8*sh_widx +: 8] <= fx_data;
        if (sh_widx == 2'd3) begin
          cfg_word <= {fx_data, shadow_reg[23:0]};
          cfg_upd  <= 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------ event FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wptr_reg, rptr_reg;
  logic [CW-1:0] count_reg;
  logic          ovf_reg;
  logic          empty, full, pop_eff, push_eff, ovf_set;
  logic [5:0]    count6;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CW'(FIFO_DEPTH));
  assign ev_full  = full;
  // A pop on an empty FIFO does nothing; a pop frees the slot for a same-cycle push.
  assign pop_eff  = fx_rd && r_pop && !empty;
  assign push_eff = ev_vld && (!full || pop_eff);
  assign ovf_set  = ev_vld && !push_eff;
  assign count6   = 6'(count_reg);

  // Storage array without reset so it can map onto RAM.
  always_ff @(posedge clk_sys) begin
    if (push_eff)
      fifo_mem[wptr_reg] <= ev_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push_eff) wptr_reg <= wptr_reg + 1'b1;
      if (pop_eff)  rptr_reg <= rptr_reg + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky overflow; a status read clears it unless an overflow lands in the same cycle.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst)
      ovf_reg <= 1'b0;
    else if (ovf_set)
      ovf_reg <= 1'b1;
    else if (fx_rd && r_stat)
      ovf_reg <= 1'b0;
  end

  // ------------------------------------------------------------- read path
  logic [7:0] rd_byte;

  // Select the byte addressed by fx_raddr from the current (pre-edge) state.
  always_comb begin
    rd_byte = '0;
    if (r_reg)
      rd_byte = reg_bank[ridx];
    else if (r_sh)
      rd_byte = shadow_reg[8*sh_ridx +: 8];
    else if (r_pop)
      rd_byte = empty ? 8'h00 : fifo_mem[rptr_reg];
    else if (r_stat)
      rd_byte = {ovf_reg, empty, full, count6[4:0]};
  end

  // Read data register: loads only on a read strobe and holds otherwise.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst)
      fx_q <= '0;
    else if (fx_rd)
      fx_q <= rd_byte;
  end

endmodule

// File: tb/tb_fx_slave_regs.sv
// Randomized scoreboard bench for fx_slave_regs against a queue-based model.
module tb_fx_slave_regs;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int NR = 16;
  localparam int FD = 16;

  logic           clk_sys, rst;
  logic           fx_wr, fx_rd, ev_vld;
  logic [31:0]    fx_waddr, fx_raddr;
  logic [7:0]     fx_data, ev_data, fx_q;
  logic [NR*8-1:0] reg_out;
  logic [31:0]    cfg_word;
  logic           cfg_upd, ev_full;

  fx_slave_regs #(.BASE_ADDR(BASE), .NUM_REG(NR), .FIFO_DEPTH(FD)) dut (
    .clk_sys(clk_sys), .rst(rst),
    .fx_wr(fx_wr), .fx_waddr(fx_waddr), .fx_data(fx_data),
    .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q),
    .reg_out(reg_out), .cfg_word(cfg_word), .cfg_upd(cfg_upd),
    .ev_data(ev_data), .ev_vld(ev_vld), .ev_full(ev_full)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Reference model: plain arrays and a queue.
  logic [7:0]  m_regs [NR];
  logic [31:0] m_shadow, m_cfg;
  bit          m_upd, m_ovf;
  logic [7:0]  m_fifo [$];
  logic [7:0]  exp_q  [$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_shadow = '0;
    m_cfg    = '0;
    m_upd    = 0;
    m_ovf    = 0;
    m_fifo.delete();
    exp_q.delete();
  endfunction

  // Applies one clock edge worth of bus/event activity to the model.
  function automatic void model_step(input bit wr, input logic [31:0] wa, input logic [7:0] wd,
                                     input bit rd, input logic [31:0] ra,
                                     input bit ev, input logic [7:0] ed);
    logic [31:0] off;
    logic [7:0]  v;
    if (rd) begin
      v = 8'h00;
      if (ra >= BASE) begin
        off = ra - BASE;
        if (off < NR) v = m_regs[off];
        else if (off < NR + 4) v = m_shadow[8*(off-NR) +: 8];
        else if (off == NR + 4) begin
          if (m_fifo.size() > 0) v = m_fifo.pop_front();
        end else if (off == NR + 5) begin
          v = {m_ovf, m_fifo.size() == 0, m_fifo.size() == FD, 5'(m_fifo.size())};
          m_ovf = 0;
        end
      end
      exp_q.push_back(v);
    end
    if (ev) begin
      if (m_fifo.size() < FD) m_fifo.push_back(ed);
      else m_ovf = 1;
    end
    m_upd = 0;
    if (wr && wa >= BASE) begin
      off = wa - BASE;
      if (off < NR) m_regs[off] = wd;
      else if (off < NR + 4) begin
        m_shadow[8*(off-NR) +: 8] = wd;
        if (off == NR + 3) begin
          m_cfg = m_shadow;
          m_upd = 1;
        end
      end
    end
  endfunction

  // Monitor: a read strobe seen at an edge means fx_q holds a new result.
  logic rd_d;
  always @(posedge clk_sys or posedge rst) begin
    if (rst) rd_d <= 1'b0;
    else     rd_d <= fx_rd;
  end

  // Compare DUT outputs with the scoreboard half a cycle after each edge.
  always @(negedge clk_sys) begin
    logic [NR*8-1:0] packed_regs;
    logic [7:0] e;
    if (rd_d) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL fx_q_unexpected: got %0h expected no read data", fx_q);
      end else begin
        e = exp_q.pop_front();
        chk("fx_q", 128'(fx_q), 128'(e));
      end
    end
    for (int i = 0; i < NR; i++) packed_regs[8*i +: 8] = m_regs[i];
    chk("reg_out", 128'(reg_out), 128'(packed_regs));
    chk("cfg_word", 128'(cfg_word), 128'(m_cfg));
    chk("cfg_upd", 128'(cfg_upd), 128'(m_upd));
    chk("ev_full", 128'(ev_full), 128'(m_fifo.size() == FD));
  end

  task automatic cyc(input bit wr, input logic [31:0] wa, input logic [7:0] wd,
                     input bit rd, input logic [31:0] ra,
                     input bit ev, input logic [7:0] ed);
    fx_wr = wr; fx_waddr = wa; fx_data = wd;
    fx_rd = rd; fx_raddr = ra;
    ev_vld = ev; ev_data = ed;
    @(posedge clk_sys);
    model_step(wr, wa, wd, rd, ra, ev, ed);
    #1;
    fx_wr = 0; fx_rd = 0; ev_vld = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    cyc(1, a, d, 0, '0, 0, '0);
  endtask
  task automatic rd(input logic [31:0] a);
    cyc(0, '0, '0, 1, a, 0, '0);
  endtask
  task automatic push(input logic [7:0] d);
    cyc(0, '0, '0, 0, '0, 1, d);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    m_reset();
    repeat (n) @(posedge clk_sys);
    #1;
    rst = 1'b0;
  endtask

  localparam logic [31:0] SH   = BASE + NR;
  localparam logic [31:0] POP  = BASE + NR + 4;
  localparam logic [31:0] STAT = BASE + NR + 5;

  initial begin
    fx_wr = 0; fx_rd = 0; ev_vld = 0;
    fx_waddr = '0; fx_raddr = '0; fx_data = '0; ev_data = '0;
    rst = 1'b1;
    m_reset();
    #1;
    do_reset(2);
    cyc(0, '0, '0, 0, '0, 0, '0);

    // Register write/readback.
    wr(BASE + 3, 8'hA5);
    rd(BASE + 3);
    cyc(0, '0, '0, 0, '0, 0, '0);

    // Shadow staging then commit.
    wr(SH + 0, 8'h11); wr(SH + 1, 8'h22); wr(SH + 2, 8'h33);
    wr(SH + 3, 8'h44);
    rd(SH + 1);
    cyc(0, '0, '0, 0, '0, 0, '0);

    // Fill FIFO, overflow, status twice.
    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'h99);
    rd(STAT);
    rd(STAT);

    // Drain past empty, then status.
    for (int i = 0; i < 17; i++) rd(POP);
    rd(STAT);

    // Unmapped reads and writes.
    rd(BASE - 1);
    rd(BASE + NR + 6);
    wr(BASE - 1, 8'hFF);
    wr(BASE + NR + 6, 8'hFF);
    wr(POP, 8'hFF);
    wr(STAT, 8'hFF);
    rd(BASE + 3);

    // Same-cycle write and read of one address returns old data.
    cyc(1, BASE + 2, 8'h77, 1, BASE + 2, 0, '0);
    rd(BASE + 2);

    // Full FIFO with simultaneous push and pop: no overflow.
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
    cyc(0, '0, '0, 1, POP, 1, 8'hEE);
    rd(STAT);
    // Status read colliding with an overflow: ovf ends set.
    push(8'h55);
    cyc(0, '0, '0, 1, STAT, 1, 8'h66);
    rd(STAT);
    rd(STAT);
    // Empty FIFO with simultaneous push and pop.
    for (int i = 0; i < 16; i++) rd(POP);
    cyc(0, '0, '0, 1, POP, 1, 8'h3C);
    rd(STAT);
    rd(POP);

    // Reset in the middle of FIFO activity with a read in flight.
    for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
    wr(BASE + 7, 8'h12);
    fx_rd = 1; fx_raddr = BASE + 7;
    @(posedge clk_sys);
    #1;
    fx_rd = 0;
    do_reset(2);
    rd(STAT);
    cyc(0, '0, '0, 0, '0, 0, '0);

    // Randomized traffic across the window and its edges.
    for (int n = 0; n < 3000; n++) begin
      bit w, r, e;
      logic [31:0] wa, ra;
      w  = ($urandom_range(0, 9) < 3);
      r  = ($urandom_range(0, 9) < 5);
      e  = ($urandom_range(0, 9) < 4);
      wa = BASE - 2 + 32'($urandom_range(0, NR + 9));
      ra = BASE - 2 + 32'($urandom_range(0, NR + 9));
      if ($urandom_range(0, 499) == 0)
        do_reset(1);
      else
        cyc(w, wa, 8'($urandom), r, ra, e, 8'($urandom));
    end
    cyc(0, '0, '0, 0, '0, 0, '0);
    cyc(0, '0, '0, 0, '0, 0, '0);

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL fx_q_missing: got %0d unconsumed reads expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
